load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-003 SHALL have port req_valid, input, 1, access request from EX stage.
REQ-004 SHALL have port req_write, input, 1; 1 = store, 0 = load.
REQ-005 SHALL have port req_size, input, 2; 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-006 SHALL have port req_unsigned, input, 1; 1 = zero-extend loads, 0 = sign-extend loads.
REQ-007 SHALL have port req_addr, input, 32, byte address.
REQ-008 SHALL have port req_wdata, input, 32, store data, right-aligned for sub-word sizes.
REQ-009 SHALL have port busy, output, 1, pipeline stall; high whenever state != IDLE.
REQ-010 SHALL have port resp_valid, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata, output, 32, extended load result; 0 for stores and faults.
REQ-012 SHALL have port misalign, output, 1, fault flag qualified by resp_valid.
REQ-013 SHALL have ports mem_read and mem_write, output, 1 each, data memory strobes.
REQ-014 SHALL have ports mem_addr and mem_wdata, output, 32 each, word index and write word.
REQ-015 SHALL have port mem_rdata, input, 32; valid the cycle after mem_read is sampled high.

Function
REQ-016 SHALL implement states IDLE, LD_WAIT, RMW_WAIT, RESP.
REQ-017 SHALL accept a request only when req_valid=1 in IDLE; it latches all req_* fields at that edge and ignores req_valid in other states.
REQ-018 SHALL drive mem_addr = {2'b00, addr[31:2]}; no range check.
REQ-019 SHALL flag misalign for: halfword with addr[0]=1; word with addr[1:0]!=0; size 11.
- No memory strobe.
- IDLE->RESP; latency 1.
REQ-020 SHALL handle an aligned word store as follows:
- In IDLE, on the accept cycle, combinationally assert mem_write=1 with mem_wdata=req_wdata.
- IDLE->RESP; latency 1.
REQ-021 SHALL handle a load as follows:
- mem_read=1 on the accept cycle; IDLE->LD_WAIT.
- In LD_WAIT, extract lane and extend mem_rdata, register the result into resp_rdata; LD_WAIT->RESP.
- Latency 2.
REQ-022 SHALL use little-endian lanes: byte k = bits 8k+7:8k; halfword at addr[1]=h = bits 16h+15:16h.
REQ-023 SHALL handle a sub-word store as read-modify-write:
- mem_read=1 on the accept cycle; IDLE->RMW_WAIT.
- In RMW_WAIT, mem_write=1 with mem_wdata = mem_rdata with only the addressed lane(s) replaced by req_wdata low bits; RMW_WAIT->RESP.
- Latency 2.
REQ-024 SHALL in RESP assert resp_valid=1 for exactly one cycle, then RESP->IDLE; the next request is acceptable in the following cycle.
REQ-025 SHALL keep mem_read and mem_write mutually exclusive; never both 1 in one cycle.
REQ-026 SHALL hold mem_read=mem_write=0 in RESP and LD_WAIT, except mem_write in RMW_WAIT only.
REQ-027 SHALL hold resp_rdata and misalign stable from RESP until the next RESP.
REQ-028 SHALL treat req_unsigned as don't-care for stores and word loads.

Reset
REQ-029 SHALL, while rst=1, force state IDLE and drive busy, resp_valid, misalign, mem_read, mem_write = 0, and resp_rdata, mem_addr, mem_wdata = 0.
REQ-030 SHALL abandon any in-flight access on reset, including an RMW between read and write; no partial write is issued, and no resp_valid occurs for it.

Verification
REQ-031 SHALL cover word store then load: store 0xDEADBEEF to 0x10 gives mem_write at cycle 0 with mem_addr=4; load of 0x10 gives resp_valid at cycle 2 with resp_rdata=0xDEADBEEF.
REQ-032 SHALL cover signed byte load: word 0x80FF7F01 at index 1, signed byte load at 0x07 gives 0xFFFFFF80; the same load with req_unsigned=1 gives 0x00000080.
REQ-033 SHALL cover byte RMW: word 0x11223344, byte store of 0xAA at offset 2 gives mem_write data 0x11AA3344 in RMW_WAIT, and busy high for 2 cycles.
REQ-034 SHALL cover misalignment: halfword load at 0x03 gives resp_valid at cycle 1 with misalign=1, resp_rdata=0, and no mem strobes.
REQ-035 SHALL cover reset mid-RMW: assert rst in RMW_WAIT and check that mem_write never goes high, the memory word is unchanged, and busy=0 immediately.
REQ-036 SHALL cover back-to-back requests: req_valid held high through busy is accepted only in IDLE, one access per response, with no dropped or duplicated access.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: single-port data memory access unit with sign/zero-extended loads,
// misalignment faults and read-modify-write sub-word stores.
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        misalign,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    localparam logic [1:0] IDLE = 2'd0, LD_WAIT = 2'd1, RMW_WAIT = 2'd2, RESP = 2'd3;

    logic [1:0]  state;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [31:0] addr_q;
    logic [15:0] wdata_q;
    logic        accept, fault, word_store;
    logic [4:0]  shift;
    logic [31:0] lane, load_data, mask, merged;

    assign accept     = state == IDLE && req_valid && !rst;
    assign fault      = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
                        (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    assign word_store = req_write && req_size == 2'b10;

    // Halfwords are 2-byte aligned here, so the byte shift also selects the halfword lane.
    assign shift     = {addr_q[1:0], 3'b000};
    assign lane      = mem_rdata >> shift;
    assign load_data = size_q == 2'b10 ? mem_rdata :
                       size_q == 2'b01 ? {unsigned_q ? 16'h0 : {16{lane[15]}}, lane[15:0]} :
                                         {unsigned_q ? 24'h0 : {24{lane[7]}}, lane[7:0]};
    assign mask      = (size_q == 2'b00 ? 32'h0000_00FF : 32'h0000_FFFF) << shift;
    assign merged    = (mem_rdata & ~mask) |
                       ((size_q == 2'b00 ? {4{wdata_q[7:0]}} : {2{wdata_q}}) & mask);

    assign busy       = state != IDLE;
    assign resp_valid = state == RESP;
    assign mem_read   = accept && !fault && !word_store;
    assign mem_write  = (accept && !fault && word_store) || state == RMW_WAIT;
    assign mem_addr   = rst ? 32'h0 : {2'b00, state == IDLE ? req_addr[31:2] : addr_q[31:2]};
    assign mem_wdata  = !mem_write ? 32'h0 : state == RMW_WAIT ? merged : req_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 16'h0;
            resp_rdata <= 32'h0;
            misalign   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    size_q     <= req_size;
                    unsigned_q <= req_unsigned;
                    addr_q     <= req_addr;
                    wdata_q    <= req_wdata[15:0];
                    if (fault || word_store) begin
                        state      <= RESP;
                        resp_rdata <= 32'h0;
                        misalign   <= fault;
                    end else begin
                        state <= req_write ? RMW_WAIT : LD_WAIT;
                    end
                end
                LD_WAIT: begin
                    resp_rdata <= load_data;
                    misalign   <= 1'b0;
                    state      <= RESP;
                end
                RMW_WAIT: begin
                    resp_rdata <= 32'h0;
                    misalign   <= 1'b0;
                    state      <= RESP;
                end
                RESP: state <= IDLE;
            endcase
        end
    end
endmodule
